// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: requester indices, bus widths, PC address.
package wb_arbiter_pkg;

  localparam int NREQ    = 3;
  localparam int DW      = 16;
  localparam int AW      = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_RMW = 2;

  localparam logic [AW-1:0] REG_PC = 3'b011;

  // Pointer successor with 2 -> 0 wrap.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// 3-way round-robin arbiter: combinational one-hot grant, pointer moves past each winner.
// Grant is forced to zero while reset is asserted.
module rr_arb3
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  logic [1:0] ptr;
  logic [1:0] win;

  always_comb begin
    gnt = 3'b000;
    if (!rst) begin
      case (ptr)
        2'd0: begin
          if      (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
        2'd1: begin
          if      (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        default: begin
          if      (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
      endcase
    end
  end

  always_comb begin
    win = 2'd0;
    if (gnt[1]) win = 2'd1;
    if (gnt[2]) win = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 2'd0;
    else if (|gnt)
      ptr <= rr_next(win);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/LSU/RMW per cycle and registers its register, PC and
// flags writes one cycle later; keeps a scoreboard of destinations reserved by issue.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      d_wr,
  input  logic [NREQ*AW-1:0]   d_adr,
  input  logic [NREQ*DW-1:0]   d_val,
  input  logic [NREQ-1:0]      s_wr,
  input  logic [NREQ*DW-1:0]   s_val,
  output logic [NREQ-1:0]      gnt,
  output logic                 rf_d_wr,
  output logic [AW-1:0]        rf_d_adr,
  output logic [DW-1:0]        rf_d_val,
  output logic                 rf_sf_wr,
  output logic [DW-1:0]        rf_sf_val,
  output logic                 pc_wr,
  output logic [DW-1:0]        pc_val,
  input  logic                 iss_valid,
  input  logic                 iss_rd_wr,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_stall,
  output logic [7:0]           busy
);

  logic          xfer;
  logic          sel_d_wr;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_val;
  logic          sel_s_wr;
  logic [DW-1:0] sel_sval;
  logic          do_rf;
  logic          do_pc;
  logic          do_sf;
  logic          iss_set;
  logic [7:0]    busy_nxt;

  rr_arb3 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign xfer = |(req & gnt);

  always_comb begin
    sel_d_wr = 1'b0;
    sel_adr  = '0;
    sel_val  = '0;
    sel_s_wr = 1'b0;
    sel_sval = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_d_wr = d_wr[i];
        sel_adr  = d_adr[i*AW +: AW];
        sel_val  = d_val[i*DW +: DW];
        sel_s_wr = s_wr[i];
        sel_sval = s_val[i*DW +: DW];
      end
    end
  end

  // Writes to the PC address are steered to the PC port instead of the register file.
  assign do_rf = xfer & sel_d_wr & (sel_adr != REG_PC);
  assign do_pc = xfer & sel_d_wr & (sel_adr == REG_PC);
  assign do_sf = xfer & sel_s_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_d_wr   <= 1'b0;
      rf_d_adr  <= '0;
      rf_d_val  <= '0;
      rf_sf_wr  <= 1'b0;
      rf_sf_val <= '0;
      pc_wr     <= 1'b0;
      pc_val    <= '0;
    end else begin
      rf_d_wr  <= do_rf;
      rf_sf_wr <= do_sf;
      pc_wr    <= do_pc;
      if (do_rf) begin
        rf_d_adr <= sel_adr;
        rf_d_val <= sel_val;
      end
      if (do_pc)
        pc_val <= sel_val;
      if (do_sf)
        rf_sf_val <= sel_sval;
    end
  end

  assign iss_stall = iss_valid & iss_rd_wr & busy[iss_rd];
  assign iss_set   = iss_valid & iss_rd_wr & ~iss_stall;

  // Clear first, then set, so a same-cycle reservation of a retiring destination survives.
  always_comb begin
    busy_nxt = busy;
    if (xfer & sel_d_wr)
      busy_nxt[sel_adr] = 1'b0;
    if (iss_set)
      busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= 8'h00;
    else
      busy <= busy_nxt;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run against a
// queue-free behavioural model of grant order, write steering and the scoreboard.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  d_wr = '0;
  logic [2:0]  s_wr = '0;
  logic [2:0]  r_adr [3];
  logic [15:0] r_val [3];
  logic [15:0] r_sval[3];
  logic [8:0]  d_adr;
  logic [47:0] d_val;
  logic [47:0] s_val;
  logic [2:0]  gnt;
  logic        rf_d_wr, rf_sf_wr, pc_wr;
  logic [2:0]  rf_d_adr;
  logic [15:0] rf_d_val, rf_sf_val, pc_val;
  logic        iss_valid = 1'b0, iss_rd_wr = 1'b0;
  logic [2:0]  iss_rd = '0;
  logic        iss_stall;
  logic [7:0]  busy;

  int chk = 0;
  int err = 0;

  // Reference model state
  int          m_rr;
  logic [7:0]  m_busy;
  logic        m_rf_d_wr, m_rf_sf_wr, m_pc_wr;
  logic [2:0]  m_rf_d_adr;
  logic [15:0] m_rf_d_val, m_rf_sf_val, m_pc_val;

  assign d_adr = {r_adr[2], r_adr[1], r_adr[0]};
  assign d_val = {r_val[2], r_val[1], r_val[0]};
  assign s_val = {r_sval[2], r_sval[1], r_sval[0]};

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .d_wr(d_wr), .d_adr(d_adr), .d_val(d_val),
    .s_wr(s_wr), .s_val(s_val), .gnt(gnt),
    .rf_d_wr(rf_d_wr), .rf_d_adr(rf_d_adr), .rf_d_val(rf_d_val),
    .rf_sf_wr(rf_sf_wr), .rf_sf_val(rf_sf_val), .pc_wr(pc_wr), .pc_val(pc_val),
    .iss_valid(iss_valid), .iss_rd_wr(iss_rd_wr), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .busy(busy)
  );

  function automatic int win_of(input logic [2:0] r, input int rr);
    for (int k = 0; k < 3; k++)
      if (r[(rr + k) % 3]) return (rr + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] exp_gnt(input logic [2:0] r, input int rr);
    int w;
    w = win_of(r, rr);
    return (w < 0) ? 3'b000 : 3'(1 << w);
  endfunction

  function automatic logic exp_stall();
    return iss_valid && iss_rd_wr && m_busy[iss_rd];
  endfunction

  task automatic model_reset();
    m_rr = 0; m_busy = 8'h00;
    m_rf_d_wr = 0; m_rf_sf_wr = 0; m_pc_wr = 0;
    m_rf_d_adr = 0; m_rf_d_val = 0; m_rf_sf_val = 0; m_pc_val = 0;
  endtask

  task automatic clear_inputs();
    req = 0; d_wr = 0; s_wr = 0; iss_valid = 0; iss_rd_wr = 0; iss_rd = 0;
    for (int i = 0; i < 3; i++) begin r_adr[i] = 0; r_val[i] = 0; r_sval[i] = 0; end
  endtask

  // Advances the model on the current inputs, then the DUT by one edge.
  task automatic tick();
    int w;
    logic [7:0] nb;
    logic set;
    w = win_of(req, m_rr);
    set = iss_valid && iss_rd_wr && !m_busy[iss_rd];
    nb = m_busy;
    m_rf_d_wr = 0; m_rf_sf_wr = 0; m_pc_wr = 0;
    if (w >= 0) begin
      m_rr = (w + 1) % 3;
      if (d_wr[w]) begin
        nb[r_adr[w]] = 1'b0;
        if (r_adr[w] == 3) begin
          m_pc_wr = 1; m_pc_val = r_val[w];
        end else begin
          m_rf_d_wr = 1; m_rf_d_adr = r_adr[w]; m_rf_d_val = r_val[w];
        end
      end
      if (s_wr[w]) begin
        m_rf_sf_wr = 1; m_rf_sf_val = r_sval[w];
      end
    end
    if (set) nb[iss_rd] = 1'b1;
    m_busy = nb;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; req = 3'b111;
    #1;
    chk++; if (gnt !== 3'b000) begin err++; $display("FAIL reset_gnt got %b exp 000", gnt); end
    @(posedge clk); #1;
    chk++;
    if ({rf_d_wr, rf_sf_wr, pc_wr, rf_d_adr, rf_d_val, rf_sf_val, pc_val, busy} !== '0) begin
      err++; $display("FAIL reset_outs got %b%b%b %h %h %h %h %h exp all zero",
        rf_d_wr, rf_sf_wr, pc_wr, rf_d_adr, rf_d_val, rf_sf_val, pc_val, busy);
    end
    rst = 0; req = 0; model_reset();
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [6];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk++; if (gnt !== seq[c]) begin err++; $display("FAIL rr_seq%0d got %b exp %b", c, gnt, seq[c]); end
      tick();
      chk++;
      if ({rf_d_wr, rf_sf_wr, pc_wr} !== 3'b000) begin
        err++; $display("FAIL rr_nostrobe%0d got %b exp 000", c, {rf_d_wr, rf_sf_wr, pc_wr});
      end
    end
    req = 0;
  endtask

  task automatic test_alu_write();
    clear_inputs();
    req[REQ_ALU] = 1; d_wr[REQ_ALU] = 1; r_adr[REQ_ALU] = 3'd2; r_val[REQ_ALU] = 16'hBEEF;
    s_wr[REQ_ALU] = 1; r_sval[REQ_ALU] = 16'h0003;
    tick();
    chk++;
    if ({rf_d_wr, rf_d_adr, rf_d_val, rf_sf_wr, rf_sf_val, pc_wr} !== {1'b1, 3'd2, 16'hBEEF, 1'b1, 16'h0003, 1'b0}) begin
      err++; $display("FAIL alu_write got %b %h %h %b %h pc %b exp 1 2 beef 1 0003 pc 0",
        rf_d_wr, rf_d_adr, rf_d_val, rf_sf_wr, rf_sf_val, pc_wr);
    end
    clear_inputs();
    tick();
    chk++;
    if ({rf_d_wr, rf_sf_wr, pc_wr, rf_d_adr, rf_d_val, rf_sf_val} !== {3'b000, 3'd2, 16'hBEEF, 16'h0003}) begin
      err++; $display("FAIL idle_hold got %b %h %h %h exp 000 2 beef 0003",
        {rf_d_wr, rf_sf_wr, pc_wr}, rf_d_adr, rf_d_val, rf_sf_val);
    end
  endtask

  task automatic test_pc_write();
    clear_inputs();
    req[REQ_LSU] = 1; d_wr[REQ_LSU] = 1; r_adr[REQ_LSU] = 3'd3; r_val[REQ_LSU] = 16'h1234;
    tick();
    chk++;
    if ({pc_wr, pc_val, rf_d_wr, rf_d_val} !== {1'b1, 16'h1234, 1'b0, 16'hBEEF}) begin
      err++; $display("FAIL pc_write got pc %b %h rf %b %h exp pc 1 1234 rf 0 beef",
        pc_wr, pc_val, rf_d_wr, rf_d_val);
    end
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    iss_valid = 1; iss_rd_wr = 1; iss_rd = 3'd5;
    tick();
    chk++; if (busy !== 8'h20) begin err++; $display("FAIL sb_reserve got %h exp 20", busy); end
    #1;
    chk++; if (iss_stall !== 1'b1) begin err++; $display("FAIL sb_stall got %b exp 1", iss_stall); end
    iss_rd = 3'd4;
    #1;
    chk++; if (iss_stall !== 1'b0) begin err++; $display("FAIL sb_nostall got %b exp 0", iss_stall); end
    iss_valid = 0;
    req[REQ_ALU] = 1; d_wr[REQ_ALU] = 1; r_adr[REQ_ALU] = 3'd5; r_val[REQ_ALU] = 16'h5555;
    tick();
    chk++; if (busy !== 8'h00) begin err++; $display("FAIL sb_clear got %h exp 00", busy); end
    // Writeback to 5 coincident with a fresh reservation of 5: reservation wins.
    iss_valid = 1; iss_rd = 3'd5;
    tick();
    chk++; if (busy !== 8'h20) begin err++; $display("FAIL sb_set_wins got %h exp 20", busy); end
    chk++; if (rf_d_wr !== 1'b1 || rf_d_adr !== 3'd5) begin
      err++; $display("FAIL sb_wb got %b %h exp 1 5", rf_d_wr, rf_d_adr); end
    clear_inputs();
    r_adr[REQ_LSU] = 3'd3; req[REQ_LSU] = 1; d_wr[REQ_LSU] = 1;
    iss_valid = 1; iss_rd_wr = 1; iss_rd = 3'd3;
    tick();
    chk++; if (busy !== 8'h28) begin err++; $display("FAIL sb_pc_set got %h exp 28", busy); end
    clear_inputs();
    req[REQ_RMW] = 1; d_wr[REQ_RMW] = 1; r_adr[REQ_RMW] = 3'd3;
    tick();
    chk++; if (busy !== 8'h20) begin err++; $display("FAIL sb_pc_clear got %h exp 20", busy); end
    clear_inputs();
  endtask

  task automatic test_flags_conflict();
    logic [15:0] seen [2];
    clear_inputs();
    req = 3'b101; s_wr = 3'b101;
    r_sval[REQ_ALU] = 16'h00AA; r_sval[REQ_RMW] = 16'h0055;
    for (int c = 0; c < 2; c++) begin
      logic [2:0] g;
      #1;
      g = exp_gnt(req, m_rr);
      chk++; if (gnt !== g) begin err++; $display("FAIL flags_gnt%0d got %b exp %b", c, gnt, g); end
      tick();
      req = req & ~g;
      seen[c] = rf_sf_val;
      chk++;
      if (rf_sf_wr !== 1'b1 || rf_sf_val !== m_rf_sf_val) begin
        err++; $display("FAIL flags_wr%0d got %b %h exp 1 %h", c, rf_sf_wr, rf_sf_val, m_rf_sf_val);
      end
    end
    chk++;
    if (seen[0] === seen[1]) begin err++; $display("FAIL flags_distinct got %h %h exp differing", seen[0], seen[1]); end
    clear_inputs();
    tick();
    chk++; if (rf_sf_wr !== 1'b0) begin err++; $display("FAIL flags_idle got %b exp 0", rf_sf_wr); end
  endtask

  task automatic test_reset_mid_transfer();
    clear_inputs();
    req[REQ_LSU] = 1; d_wr[REQ_LSU] = 1; r_adr[REQ_LSU] = 3'd4; r_val[REQ_LSU] = 16'hAAAA;
    s_wr[REQ_LSU] = 1; r_sval[REQ_LSU] = 16'h0001;
    iss_valid = 1; iss_rd_wr = 1; iss_rd = 3'd6;
    #1;
    rst = 1;
    #1;
    chk++; if (gnt !== 3'b000) begin err++; $display("FAIL rstmid_gnt got %b exp 000", gnt); end
    @(posedge clk); #1;
    rst = 0; model_reset(); clear_inputs();
    tick();
    chk++;
    if ({rf_d_wr, rf_sf_wr, pc_wr} !== 3'b000 || busy !== 8'h00) begin
      err++; $display("FAIL rstmid_outs got %b busy %h exp 000 busy 00", {rf_d_wr, rf_sf_wr, pc_wr}, busy);
    end
    req = 3'b111;
    #1;
    chk++; if (gnt !== 3'b001) begin err++; $display("FAIL rstmid_rr got %b exp 001", gnt); end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [2:0] pend;
    int waitc [3];
    pend = 0;
    for (int i = 0; i < 3; i++) waitc[i] = 0;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      logic [2:0] g;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(0, 9) < 5)) begin
          pend[i] = 1;
          d_wr[i] = 1'($urandom_range(0, 3) != 0);
          s_wr[i] = 1'($urandom_range(0, 1));
          r_adr[i] = 3'($urandom_range(0, 7));
          r_val[i] = 16'($urandom);
          r_sval[i] = 16'($urandom);
        end
      end
      req = pend;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd_wr = 1'($urandom_range(0, 3) != 0);
      iss_rd = 3'($urandom_range(0, 7));
      #1;
      g = exp_gnt(req, m_rr);
      chk++; if (gnt !== g) begin err++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, gnt, g); end
      chk++; if (iss_stall !== exp_stall()) begin
        err++; $display("FAIL rnd_stall c%0d got %b exp %b", c, iss_stall, exp_stall()); end
      for (int i = 0; i < 3; i++) waitc[i] = (req[i] && !g[i]) ? waitc[i] + 1 : 0;
      chk++;
      if (waitc[0] > 2 || waitc[1] > 2 || waitc[2] > 2) begin
        err++; $display("FAIL rnd_starve c%0d got waits %0d %0d %0d exp at most 2",
          c, waitc[0], waitc[1], waitc[2]);
      end
      tick();
      pend = pend & ~g;
      chk++;
      if ({rf_d_wr, rf_d_adr, rf_d_val, rf_sf_wr, rf_sf_val, pc_wr, pc_val, busy} !==
          {m_rf_d_wr, m_rf_d_adr, m_rf_d_val, m_rf_sf_wr, m_rf_sf_val, m_pc_wr, m_pc_val, m_busy}) begin
        err++;
        $display("FAIL rnd_regs c%0d got rf %b %h %h sf %b %h pc %b %h busy %h exp rf %b %h %h sf %b %h pc %b %h busy %h",
          c, rf_d_wr, rf_d_adr, rf_d_val, rf_sf_wr, rf_sf_val, pc_wr, pc_val, busy,
          m_rf_d_wr, m_rf_d_adr, m_rf_d_val, m_rf_sf_wr, m_rf_sf_val, m_pc_wr, m_pc_val, m_busy);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_round_robin();
    test_alu_write();
    test_pc_write();
    test_scoreboard();
    test_flags_conflict();
    test_reset_mid_transfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports listed below, clock and reset first.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req[2:0]  in  3  writeback request; bit 0 ALU, bit 1 LSU, bit 2 RMW.
REQ-005 d_wr[2:0] / d_adr[3*3] / d_val[3*16]  in  per-requester register-write enable, address, data.
REQ-006 s_wr[2:0] / s_val[3*16]  in  per-requester flags-write enable and value.
REQ-007 gnt[2:0]  out  3  one-hot grant, combinational from req and rr pointer.
REQ-008 rf_d_wr, rf_d_adr[2:0], rf_d_val[15:0]  out  registered register-file write port.
REQ-009 rf_sf_wr, rf_sf_val[15:0]  out  registered flags write port; the RMW flags input of the register file is tied low.
REQ-010 pc_wr, pc_val[15:0]  out  registered PC load, taken when destination is 3'b011.
REQ-011 iss_valid, iss_rd_wr, iss_rd[2:0]  in  issue-stage reservation of a destination.
REQ-012 iss_stall  out  1  combinational; high when iss_valid & iss_rd_wr & busy[iss_rd].
REQ-013 busy[7:0]  out  8  registered scoreboard of pending destinations.

Function
REQ-014 Transfer SHALL occur when req[i] & gnt[i]; requester holds d_*/s_* stable while req[i] & ~gnt[i].
REQ-015 At most one gnt bit high per cycle; gnt SHALL be zero when req is zero.
REQ-016 Arbitration SHALL be round-robin: search starts at rr, wraps 2->0; rr reset 0.
REQ-017 After a transfer from i, rr SHALL become (i+1) mod 3; with no transfer rr holds.
REQ-018 Any continuously requesting requester SHALL be granted within 3 cycles.
REQ-019 Cycle after transfer: rf_d_wr = d_wr[i] & (d_adr[i] != 3'b011), rf_d_adr/rf_d_val = granted values.
REQ-020 Cycle after transfer: pc_wr = d_wr[i] & (d_adr[i] == 3'b011), pc_val = d_val[i]; rf_d_wr low.
REQ-021 Cycle after transfer: rf_sf_wr = s_wr[i], rf_sf_val = s_val[i]; only one flags writer per cycle.
REQ-022 rf_d_wr, rf_sf_wr, pc_wr SHALL be low in any cycle following a no-transfer cycle; data outputs hold.
REQ-023 Latency SHALL be exactly 1 cycle from transfer to register-file write strobe.
REQ-024 Scoreboard SHALL set busy[iss_rd] on iss_valid & iss_rd_wr & ~iss_stall.
REQ-025 Scoreboard SHALL clear busy[adr] on a transfer with d_wr[i]=1 (including adr 3), same edge as output registration.
REQ-026 Simultaneous set and clear of the same bit: set SHALL win.
REQ-027 A transfer with d_wr=0 and s_wr=0 SHALL be accepted and leave all state except rr unchanged.

Reset
REQ-028 On rst: rr=0, busy=8'h00, rf_d_wr=0, rf_sf_wr=0, pc_wr=0, rf_d_adr=0, rf_d_val=0, rf_sf_val=0, pc_val=0.
REQ-029 rst mid-transfer SHALL discard the pending write; no strobe after reset deassertion until a new transfer.
REQ-030 gnt SHALL be 0 during reset regardless of req.

Structure
REQ-031 Shared package SHALL hold requester indices (ALU=0, LSU=1, RMW=2), NREQ=3, REG_PC=3'b011, width constants 16/3.
REQ-032 One sub-module rr_arb3 (3-way round-robin grant with pointer) SHALL be used; scoreboard stays inline.

Verification
REQ-033 req=3'b111 held 6 cycles from reset -> gnt sequence 001,010,100,001,010,100.
REQ-034 ALU d_wr=1 d_adr=2 d_val=16'hBEEF s_wr=1 s_val=16'h0003 -> next cycle rf_d_wr=1 adr=2 val=BEEF, rf_sf_wr=1 val=0003.
REQ-035 LSU d_wr=1 d_adr=3 d_val=16'h1234 -> next cycle pc_wr=1 pc_val=1234, rf_d_wr=0.
REQ-036 iss reserve rd=5 -> busy[5]=1; second iss rd=5 -> iss_stall=1; ALU writeback adr=5 coincident with new iss rd=5 -> busy[5] remains 1.
REQ-037 ALU and RMW both s_wr=1 same cycle -> flags written on consecutive cycles, never both in one cycle.
REQ-038 rst asserted the cycle a transfer occurs -> no rf_d_wr/rf_sf_wr/pc_wr after release, busy=0, rr=0.
